dmem_responder: RTL and testbench

- Memory-side responder for the core's data-memory load/store interface; the slave end of the CPU's data-memory port.
- Accepts one load/store request at a time over a valid/ready handshake and waits a parameterised number of cycles.
- Performs a byte/half/word access on an internal little-endian RAM and returns sign/zero-extended read data.
- Sits between the core's memory stage and data storage, so the datapath can be tested against multi-cycle memory.

---
 rtl/dmem_pkg.sv | 27 ++
 rtl/dmem_responder_if.sv | 26 ++
 rtl/dmem_lane_align.sv | 62 ++++++
 rtl/dmem_responder.sv | 115 +++++++++++
 tb/tb_dmem_responder.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: RV32I load/store funct3 codes,
// FSM states and the captured request record.
package dmem_pkg;

  localparam int DMEM_XLEN = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_ACCESS,
    S_RESP
  } dmem_state_t;

  typedef struct packed {
    logic [DMEM_XLEN-1:0] addr;
    logic                 we;
    logic [2:0]           funct3;
    logic [DMEM_XLEN-1:0] wdata;
  } dmem_req_t;

endpackage

// File: rtl/dmem_responder_if.sv
// Request/response bundle between the core's memory stage (master) and the
// data-memory responder (slave); valid/ready on both directions.
interface dmem_responder_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  req_valid;
  logic                  req_ready;
  logic [DATA_WIDTH-1:0] req_addr;
  logic                  req_we;
  logic [2:0]            req_funct3;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  rsp_err;

  modport master (
    output req_valid, req_addr, req_we, req_funct3, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_addr, req_we, req_funct3, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_lane_align.sv
// Combinational byte-lane steering: byte enables, shifted store data, extended load data, width/sign errors.
// DMEM_MISALIGN_ERR_EN: misaligned half/word accesses fault instead of being force-aligned.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [1:0]           addr_lo_i,
  input  logic [2:0]           funct3_i,
  input  logic                 we_i,
  input  logic [DMEM_XLEN-1:0] wdata_i,
  input  logic [DMEM_XLEN-1:0] raw_i,
  output logic [3:0]           be_o,
  output logic [DMEM_XLEN-1:0] wdata_o,
  output logic [DMEM_XLEN-1:0] rdata_o,
  output logic                 err_o
);
  logic [1:0]           eff_lo;
  logic [1:0]           size;
  logic                 sext;
  logic                 legal;
  logic [DMEM_XLEN-1:0] shifted;

  always_comb begin
    eff_lo = addr_lo_i;
    size   = 2'd0;
    sext   = 1'b0;
    legal  = 1'b0;
    case (funct3_i)
      F3_B:  begin legal = 1'b1; sext = 1'b1; end
      F3_H:  begin legal = 1'b1; sext = 1'b1; size = 2'd1; eff_lo[0] = 1'b0; end
      F3_W:  begin legal = 1'b1; size = 2'd2; eff_lo = 2'b00; end
      F3_BU: begin legal = ~we_i; end
      F3_HU: begin legal = ~we_i; size = 2'd1; eff_lo[0] = 1'b0; end
      default: legal = 1'b0;
    endcase
  end

  // A misaligned access is exactly one whose address the force-alignment changed.
`ifdef DMEM_MISALIGN_ERR_EN
  assign err_o = ~legal | (eff_lo != addr_lo_i);
`else
  assign err_o = ~legal;
`endif

  assign wdata_o = wdata_i << {eff_lo, 3'b000};
  assign shifted = raw_i >> {eff_lo, 3'b000};

  always_comb begin
    be_o    = 4'b0000;
    rdata_o = shifted;
    case (size)
      2'd0: begin
        be_o    = 4'b0001 << eff_lo;
        rdata_o = {{24{sext & shifted[7]}}, shifted[7:0]};
      end
      2'd1: begin
        be_o    = 4'b0011 << eff_lo;
        rdata_o = {{16{sext & shifted[15]}}, shifted[15:0]};
      end
      default: be_o = 4'b1111;
    endcase
  end
endmodule

// File: rtl/dmem_responder.sv
// Single-outstanding data-memory slave: response WAIT_CYCLES+1 edges after accept,
// held until rsp_ready; req_ready low from accept until the response is taken.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 12,
  parameter int WAIT_CYCLES = 2
) (
  input  logic            clk,
  input  logic            rst,
  dmem_responder_if.slave bus
);
  localparam int DEPTH = 2 ** (ADDR_WIDTH - 2);
  localparam int CNT_W = (WAIT_CYCLES > 1) ? $clog2(WAIT_CYCLES) : 1;

  dmem_state_t           state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  dmem_req_t             req_q, req_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [ADDR_WIDTH-3:0] widx;
  logic [DATA_WIDTH-1:0] raw_word, st_word, ld_word;
  logic [3:0]            be;
  logic                  lane_err, oor, acc_err, mem_we;

  assign widx     = req_q.addr[ADDR_WIDTH-1:2];
  assign oor      = |req_q.addr[DATA_WIDTH-1:ADDR_WIDTH];
  assign raw_word = mem[widx];
  assign acc_err  = oor | lane_err;
  // Reset wins over a store sitting in its access cycle.
  assign mem_we   = (state_q == S_ACCESS) && req_q.we && !acc_err && !rst;

  dmem_lane_align u_align (
    .addr_lo_i (req_q.addr[1:0]),
    .funct3_i  (req_q.funct3),
    .we_i      (req_q.we),
    .wdata_i   (req_q.wdata),
    .raw_i     (raw_word),
    .be_o      (be),
    .wdata_o   (st_word),
    .rdata_o   (ld_word),
    .err_o     (lane_err)
  );

  assign bus.req_ready = (state_q == S_IDLE) && !rst;
  assign bus.rsp_valid = (state_q == S_RESP);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req_valid) begin
          req_d = '{addr: bus.req_addr, we: bus.req_we,
                    funct3: bus.req_funct3, wdata: bus.req_wdata};
          if (WAIT_CYCLES == 0) begin
            state_d = S_ACCESS;
          end else begin
            state_d = S_WAIT;
            cnt_d   = CNT_W'(WAIT_CYCLES - 1);
          end
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) state_d = S_ACCESS;
        else             cnt_d   = cnt_q - CNT_W'(1);
      end
      S_ACCESS: begin
        rdata_d = (!req_q.we && !acc_err) ? ld_word : '0;
        err_d   = acc_err;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d = S_IDLE;
          rdata_d = '0;
          err_d   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      req_q   <= '0;
      rdata_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[widx][8*b +: 8] <= st_word[8*b +: 8];
      end
    end
  end
endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: vector table of load/store transactions plus
// hand-written backpressure and reset-abort sequences.
module tb_dmem_responder;
  import dmem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  dmem_responder_if #(.DATA_WIDTH(32)) bus ();

  dmem_responder #(
    .DATA_WIDTH  (32),
    .ADDR_WIDTH  (12),
    .WAIT_CYCLES (2)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[24];
  int   nvec = 0;
  int   pass_cnt = 0;
  int   total_cnt = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act !== exp) $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    else pass_cnt++;
  endtask

  task automatic add(input logic we, input logic [2:0] f3, input logic [31:0] a,
                     input logic [31:0] wd, input logic [31:0] er, input logic ee);
    vecs[nvec] = '{we, f3, a, wd, er, ee};
    nvec++;
  endtask

  // Issue one request with rsp_ready high; lat counts edges from accept to rsp_valid.
  task automatic do_txn(input logic we, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rd,
                        output logic er, output int lat);
    int n;
    @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = we;
    bus.req_funct3 = f3;
    bus.req_addr   = a;
    bus.req_wdata  = wd;
    bus.rsp_ready  = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    lat = 0;
    while (!bus.rsp_valid && lat < 50) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.rsp_valid || n >= 50) lat = -1;
    rd = bus.rsp_rdata;
    er = bus.rsp_err;
  endtask

  initial begin
    logic [31:0] rd;
    logic        er;
    int          lat;
    int          n;

    bus.req_valid  = 1'b0;
    bus.req_we     = 1'b0;
    bus.req_funct3 = 3'b000;
    bus.req_addr   = '0;
    bus.req_wdata  = '0;
    bus.rsp_ready  = 1'b1;

    // Reset: two edges with rst high
    rst = 1'b1;
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    chk("reset req_ready", {31'b0, bus.req_ready}, 32'h0);
    chk("reset rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
    chk("reset rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("reset rsp_err",   {31'b0, bus.rsp_err},   32'h0);
    rst = 1'b0;
    #1;
    chk("post-reset req_ready", {31'b0, bus.req_ready}, 32'h1);

    add(1, F3_W,   32'h010, 32'hDEADBEEF, 32'h0, 0);
    add(1, F3_W,   32'h000, 32'h11223344, 32'h0, 0);
    add(1, F3_W,   32'h020, 32'hCAFEF00D, 32'h0, 0);
    add(0, F3_W,   32'h010, 32'h0,        32'hDEADBEEF, 0);
    add(1, F3_B,   32'h013, 32'hFFFFFF81, 32'h0, 0);
    add(0, F3_B,   32'h013, 32'h0,        32'hFFFFFF81, 0);
    add(0, F3_BU,  32'h013, 32'h0,        32'h00000081, 0);
    add(0, F3_W,   32'h010, 32'h0,        32'h81ADBEEF, 0);
    add(0, F3_H,   32'h012, 32'h0,        32'hFFFF81AD, 0);
    add(0, F3_HU,  32'h010, 32'h0,        32'h0000BEEF, 0);
    add(0, F3_B,   32'h010, 32'h0,        32'hFFFFFFEF, 0);
    add(0, F3_BU,  32'h011, 32'h0,        32'h000000BE, 0);
    add(0, F3_H,   32'h000, 32'h0,        32'h00003344, 0);
    add(1, F3_H,   32'h022, 32'hBEEF1234, 32'h0, 0);
    add(0, F3_W,   32'h020, 32'h0,        32'h1234F00D, 0);
    add(0, 3'b011, 32'h010, 32'h0,        32'h0, 1);
    add(1, F3_W,   32'h1000, 32'h55555555, 32'h0, 1);
    add(0, F3_W,   32'h000, 32'h0,        32'h11223344, 0);
    add(1, F3_BU,  32'h010, 32'h0,        32'h0, 1);
    add(0, F3_W,   32'h010, 32'h0,        32'h81ADBEEF, 0);
`ifdef DMEM_MISALIGN_ERR_EN
    add(0, F3_W,   32'h011, 32'h0,        32'h0, 1);
`else
    add(0, F3_W,   32'h011, 32'h0,        32'h81ADBEEF, 0);
`endif

    for (int i = 0; i < nvec; i++) begin
      do_txn(vecs[i].we, vecs[i].f3, vecs[i].addr, vecs[i].wdata, rd, er, lat);
      chk($sformatf("vec%0d rdata", i), rd, vecs[i].exp_rdata);
      chk($sformatf("vec%0d err", i), {31'b0, er}, {31'b0, vecs[i].exp_err});
      chk($sformatf("vec%0d latency", i), lat, 32'd3);
    end

    // Backpressure: hold the response for 5 cycles while a new request waits.
    @(negedge clk);
    while (!bus.req_ready) @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b0;
    bus.req_funct3 = F3_W;
    bus.req_addr   = 32'h010;
    bus.rsp_ready  = 1'b0;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    n = 0;
    while (!bus.rsp_valid && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("bp latency", n, 32'd3);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_wdata  = 32'h0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d rsp_valid", c), {31'b0, bus.rsp_valid}, 32'h1);
      chk($sformatf("bp%0d rdata", c), bus.rsp_rdata, 32'h81ADBEEF);
      chk($sformatf("bp%0d err", c), {31'b0, bus.rsp_err}, 32'h0);
      chk($sformatf("bp%0d req_ready", c), {31'b0, bus.req_ready}, 32'h0);
    end
    bus.req_valid = 1'b0;
    bus.rsp_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp release rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
    chk("bp release rdata", bus.rsp_rdata, 32'h0);
    chk("bp release req_ready", {31'b0, bus.req_ready}, 32'h1);
    do_txn(0, F3_W, 32'h010, 32'h0, rd, er, lat);
    chk("bp ignored store", rd, 32'h81ADBEEF);

    // Reset while a store is in WAIT: the store must be dropped.
    @(negedge clk);
    while (!bus.req_ready) @(negedge clk);
    bus.req_valid  = 1'b1;
    bus.req_we     = 1'b1;
    bus.req_funct3 = F3_W;
    bus.req_addr   = 32'h020;
    bus.req_wdata  = 32'h12345678;
    @(posedge clk);
    #1;
    bus.req_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    chk("abort rsp_valid", {31'b0, bus.rsp_valid}, 32'h0);
    chk("abort req_ready", {31'b0, bus.req_ready}, 32'h1);
    repeat (4) @(posedge clk);
    do_txn(0, F3_W, 32'h020, 32'h0, rd, er, lat);
    chk("abort old value", rd, 32'h1234F00D);
    chk("abort latency", lat, 32'd3);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
